// File: rtl/truth_table_sequencer_if.sv
// Bundle of the sequencer's control, stimulus and status signals.
// master: the sequencer side; slave: the environment (start source and gate under test).
// Optional TTSEQ_FAIL_LOG_EN adds fail_valid and first_fail_idx.
interface truth_table_sequencer_if;
  logic       start;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
`ifdef TTSEQ_FAIL_LOG_EN
  logic       fail_valid;
  logic [1:0] first_fail_idx;

  modport master (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, err_cnt, fail_valid, first_fail_idx
  );

  modport slave (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, err_cnt, fail_valid, first_fail_idx
  );
`else
  modport master (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, err_cnt
  );

  modport slave (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, err_cnt
  );
`endif
endinterface

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: drives the four {a,b} vectors of a 2-input gate,
// holding each HOLD_CYCLES clocks, and compares the gate output against
// EXP_TABLE on the last cycle of each hold.
// Optional macro TTSEQ_FAIL_LOG_EN adds a first-failure log
// (fail_valid, first_fail_idx).
module truth_table_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [3:0]  EXP_TABLE   = 4'b1110
) (
  input logic                     clk,
  input logic                     rst_n,
  truth_table_sequencer_if.master bus
);

  // Last hold count; the compare happens on the edge leaving this count.
  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES must be within 2..255");
  end

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ab_q, ab_d;
  logic [2:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       mismatch;
`ifdef TTSEQ_FAIL_LOG_EN
  logic       fv_q, fv_d;
  logic [1:0] ffi_q, ffi_d;
`endif

  // Next-state, vector and scoreboard logic for the sweep.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ab_d     = 2'b00;
    err_d    = err_q;
    pass_d   = pass_q;
    mismatch = 1'b0;
`ifdef TTSEQ_FAIL_LOG_EN
    fv_d     = fv_q;
    ffi_d    = ffi_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StDrive;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
          err_d   = 3'd0;
          pass_d  = 1'b0;
`ifdef TTSEQ_FAIL_LOG_EN
          fv_d    = 1'b0;
          ffi_d   = 2'd0;
`endif
        end
      end
      StDrive: begin
        ab_d  = idx_q;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == HoldLast) begin
          mismatch = (bus.y_in != EXP_TABLE[idx_q]);
          err_d    = err_q + {2'b00, mismatch};
`ifdef TTSEQ_FAIL_LOG_EN
          if (mismatch && !fv_q) begin
            fv_d  = 1'b1;
            ffi_d = idx_q;
          end
`endif
          cnt_d = 8'd0;
          if (idx_q == 2'd3) begin
            // Pass is registered together with the move into DONE so it is
            // already valid while done is high.
            state_d = StDone;
            pass_d  = (err_d == 3'd0);
            ab_d    = 2'b00;
          end else begin
            idx_d = idx_q + 2'd1;
            ab_d  = idx_q + 2'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = 2'd0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      ab_q    <= 2'b00;
      err_q   <= 3'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

`ifdef TTSEQ_FAIL_LOG_EN
  // First-failure log registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q  <= 1'b0;
      ffi_q <= 2'd0;
    end else begin
      fv_q  <= fv_d;
      ffi_q <= ffi_d;
    end
  end

  assign bus.fail_valid     = fv_q;
  assign bus.first_fail_idx = ffi_q;
`endif

  assign bus.a_out   = ab_q[1];
  assign bus.b_out   = ab_q[0];
  assign bus.busy    = (state_q == StDrive);
  assign bus.done    = (state_q == StDone);
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_q;

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports named clk and rst_n.
REQ-002 Parameter HOLD_CYCLES, default 4: the number of clk cycles each input vector is held; legal range 2..255.
REQ-003 Parameter EXP_TABLE, default 4'b1110 (OR): bit i is the expected y_in when {a_out,b_out}=i.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to run one sweep; sampled only in IDLE.
REQ-007 y_in  input  1  output of the 2-input gate under test, sampled on clk.
REQ-008 a_out  output  1  gate input A, registered.
REQ-009 b_out  output  1  gate input B, registered.
REQ-010 busy  output  1  high while the sweep is in DRIVE.
REQ-011 done  output  1  one-cycle pulse at the end of a sweep.
REQ-012 pass  output  1  high when the last sweep had zero mismatches; held until the next accepted start.
REQ-013 err_cnt  output  3  mismatch count of the current or last sweep, range 0..4.

Function
REQ-014 The FSM SHALL have the states IDLE, DRIVE and DONE; it SHALL be in IDLE after reset.
REQ-015 In IDLE: {a_out,b_out}=2'b00 and busy=0; start=1 at an edge SHALL move to DRIVE with idx=0, hold counter=0, err_cnt=0 and pass=0.
REQ-016 In DRIVE: {a_out,b_out} SHALL equal idx, with idx running 0,1,2,3 (A is the MSB), and busy=1.
REQ-017 The hold counter SHALL increment on every edge in DRIVE; at the edge where counter==HOLD_CYCLES-1, y_in SHALL be compared with EXP_TABLE[idx].
REQ-018 On a mismatch, err_cnt SHALL increment by 1 at that edge; it cannot exceed 4.
REQ-019 At the compare edge: if idx<3, idx SHALL increment and the counter SHALL clear; if idx==3, the FSM SHALL go to DONE.
REQ-020 In DONE, done=1 for exactly one cycle, pass=(err_cnt==0) SHALL be registered, {a_out,b_out} SHALL return to 00, and the next state SHALL be IDLE.
REQ-021 Latency: with start accepted at edge k, done SHALL be high in the cycle after edge k+4*HOLD_CYCLES.
REQ-022 start in DRIVE or DONE SHALL be ignored, with no restart and no queuing.
REQ-023 err_cnt and pass SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, idx=0, counter=0, a_out=b_out=0, busy=0, done=0, pass=0, err_cnt=0, plus the macro outputs at 0.
REQ-025 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; the first start after release SHALL run a full sweep from idx 0.

Configuration
REQ-026 With macro TTSEQ_FAIL_LOG_EN defined, the block SHALL add the outputs fail_valid (1 bit) and first_fail_idx (2 bits).
REQ-027 fail_valid and first_fail_idx SHALL be cleared on an accepted start and set at the first mismatch of the sweep to that idx; later mismatches SHALL not change them.
REQ-028 Without TTSEQ_FAIL_LOG_EN, those ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 HOLD_CYCLES=4, EXP_TABLE=1110, y_in=a_out|b_out, start pulse -> vectors 00,01,10,11 held 4 cycles each; done 17 cycles after start; pass=1, err_cnt=0.
REQ-030 Same setup, y_in stuck at 0 -> err_cnt=3, pass=0; with the macro, fail_valid=1 and first_fail_idx=1.
REQ-031 EXP_TABLE=1000 (AND) against an OR gate -> err_cnt=2, pass=0, first_fail_idx=1.
REQ-032 start held high through the whole sweep -> exactly one sweep and one done pulse; a second sweep starts only if start is still high in IDLE.
REQ-033 rst_n pulsed low during idx=2 -> a_out=b_out=0, busy=0 at once, no done; a new start gives a full passing sweep.
REQ-034 HOLD_CYCLES=2 boundary -> each vector is held 2 cycles; done 9 cycles after start; compare results match REQ-029.
